// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the PC fetched after reset and the NOP word used to clear the instruction registers.
package if_fetch_stage_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD,
    DROP = ST_DROP
  } fetch_state_e;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight and hands
// fetched words to IF/ID through a valid/stall slot backed by a one-entry skid register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_pc_plus_4,
  output logic [31:0] o_Instruction
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_q, skid_d;
  logic         slotValid_q, slotValid_d;
  logic [31:0]  slotPc_q, slotPc_d;
  logic [31:0]  slotInstr_q, slotInstr_d;

  logic [31:0]  pcPlus4;
  logic [31:0]  redirectTarget;
  logic         slotFree;

  assign pcPlus4        = pc_q + 32'd4;
  assign redirectTarget = wordAlign(redirect_pc);
  assign slotFree       = !slotValid_q || !if_stall;

  assign imem_req      = (state_q == REQ) && !redirect_valid;
  assign imem_addr     = wordAlign(pc_q);
  assign o_valid       = slotValid_q;
  assign o_pc_plus_4   = slotPc_q;
  assign o_Instruction = slotInstr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    skid_d      = skid_q;
    slotValid_d = slotValid_q && if_stall;
    slotPc_d    = slotPc_q;
    slotInstr_d = slotInstr_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redirectTarget;
      end

      REQ: begin
        if (redirect_valid) begin
          pc_d = redirectTarget;
        end else if (imem_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirectTarget;
          state_d = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          pc_d = pcPlus4;
          if (slotFree) begin
            slotValid_d = 1'b1;
            slotPc_d    = pcPlus4;
            slotInstr_d = imem_rdata;
            state_d     = REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end

      // pc was already advanced when the word went into the skid register
      HOLD: begin
        if (redirect_valid) begin
          skid_d  = NOP_WORD;
          pc_d    = redirectTarget;
          state_d = REQ;
        end else if (slotFree) begin
          slotValid_d = 1'b1;
          slotPc_d    = pc_q;
          slotInstr_d = skid_q;
          state_d     = REQ;
        end
      end

      DROP: begin
        if (redirect_valid) pc_d = redirectTarget;
        if (imem_rvalid) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase

    if (redirect_valid) slotValid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      skid_q      <= NOP_WORD;
      slotValid_q <= 1'b0;
      slotPc_q    <= 32'h0000_0000;
      slotInstr_q <= NOP_WORD;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_q      <= skid_d;
      slotValid_q <= slotValid_d;
      slotPc_q    <= slotPc_d;
      slotInstr_q <= slotInstr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed steps followed by random traffic, all checked against
// a transaction-level model (expected request address plus a queue of words owed to IF/ID).
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        o_valid;
  logic [31:0] o_pc_plus_4;
  logic [31:0] o_Instruction;

  typedef struct packed {
    logic [31:0] pcPlus4;
    logic [31:0] instr;
  } slotItem_t;

  localparam logic [31:0] RESET_ADDR = 32'hBFC0_0000;

  slotItem_t   expQ[$];
  logic [31:0] reqPc;
  logic [31:0] memAddr;
  logic        memBusy;
  logic        memStale;
  logic        started;
  logic        readyKnob;
  int          memCnt;
  int          memLat;
  int          latKnob;
  int          assertCount = 0;
  int          failCount   = 0;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall      (if_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .o_valid       (o_valid),
    .o_pc_plus_4   (o_pc_plus_4),
    .o_Instruction (o_Instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memFunc(input logic [31:0] a);
    if (a == RESET_ADDR) return 32'h2408_0001;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount = assertCount + 1;
    assert (observed === expected)
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    reqPc    = RESET_ADDR;
    memAddr  = 32'h0;
    memBusy  = 1'b0;
    memStale = 1'b0;
    started  = 1'b0;
    memCnt   = 0;
    memLat   = 1;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model on the edge.
  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc);
    logic        rv;
    logic [31:0] rd;
    logic        reqExp;
    logic        consume;
    slotItem_t   item;
    rv = 1'b0;
    rd = 32'hDEAD_BEEF;
    if (memBusy) begin
      memCnt = memCnt + 1;
      if (memCnt >= memLat) begin
        rv = 1'b1;
        rd = memFunc(memAddr);
      end
    end
    if_stall       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_ready     = readyKnob;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    reqExp  = started && !memBusy && (expQ.size() < 2) && !redir;
    consume = (expQ.size() != 0) && !stall && !redir;

    @(negedge clk);
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, reqExp});
    checkOutput("imem_addr", imem_addr, reqPc);
    checkOutput("o_valid", {31'b0, o_valid}, {31'b0, (expQ.size() != 0)});
    if (expQ.size() != 0) begin
      item = expQ[0];
      checkOutput("o_pc_plus_4", o_pc_plus_4, item.pcPlus4);
      checkOutput("o_Instruction", o_Instruction, item.instr);
    end

    @(posedge clk);
    #1;
    if (redir) begin
      expQ.delete();
      reqPc = {rpc[31:2], 2'b00};
      if (memBusy && !rv) memStale = 1'b1;
    end else begin
      if (consume) void'(expQ.pop_front());
      if (rv && !memStale) begin
        item.pcPlus4 = memAddr + 32'd4;
        item.instr   = memFunc(memAddr);
        expQ.push_back(item);
        reqPc = memAddr + 32'd4;
      end
    end
    if (rv) begin
      memBusy  = 1'b0;
      memStale = 1'b0;
    end
    if (reqExp && readyKnob) begin
      memBusy = 1'b1;
      memAddr = reqPc;
      memCnt  = 0;
      memLat  = (latKnob == 0) ? int'($urandom_range(1, 3)) : latKnob;
    end
    started = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    if_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    readyKnob      = 1'b1;
    latKnob        = 1;
    resetModel();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_o_valid", {31'b0, o_valid}, 32'h0);
    checkOutput("rst_o_pc_plus_4", o_pc_plus_4, 32'h0);
    checkOutput("rst_o_Instruction", o_Instruction, 32'h0);
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, RESET_ADDR);
    rst = 1'b1;

    // First fetch with a one-cycle memory
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_req", {31'b0, imem_req}, 32'h1);
    checkOutput("t1_addr", imem_addr, 32'hBFC0_0000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_valid", {31'b0, o_valid}, 32'h1);
    checkOutput("t1_instr", o_Instruction, 32'h2408_0001);
    checkOutput("t1_pc4", o_pc_plus_4, 32'hBFC0_0004);
    checkOutput("t1_next_addr", imem_addr, 32'hBFC0_0004);

    // Stall while the second response arrives: it must go to the skid register
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t2_hold_req", {31'b0, imem_req}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t2_valid", {31'b0, o_valid}, 32'h1);
    checkOutput("t2_instr_kept", o_Instruction, 32'h2408_0001);
    checkOutput("t2_pc4_kept", o_pc_plus_4, 32'hBFC0_0004);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t2_pc4_second", o_pc_plus_4, 32'hBFC0_0008);
    checkOutput("t2_instr_second", o_Instruction, memFunc(32'hBFC0_0004));

    // Redirect while waiting: the stale response must be dropped
    latKnob = 3;
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h8000_0103);
    checkOutput("t3_valid_cleared", {31'b0, o_valid}, 32'h0);
    checkOutput("t3_addr", imem_addr, 32'h8000_0100);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t3_stale_dropped", {31'b0, o_valid}, 32'h0);
    checkOutput("t3_req", {31'b0, imem_req}, 32'h1);
    checkOutput("t3_req_addr", imem_addr, 32'h8000_0100);
    latKnob = 1;

    // Redirect in the same cycle the memory is ready
    applyStimulus(1'b0, 1'b1, 32'h0000_1000);
    checkOutput("t4_addr", imem_addr, 32'h0000_1000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t4_pc4", o_pc_plus_4, 32'h0000_1004);

    // PC wrap-around at the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("t5_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t5_valid", {31'b0, o_valid}, 32'h1);
    checkOutput("t5_pc4_wrap", o_pc_plus_4, 32'h0000_0000);
    checkOutput("t5_addr_wrap", imem_addr, 32'h0000_0000);

    // Asynchronous reset while a request is outstanding
    latKnob = 3;
    applyStimulus(1'b1, 1'b0, 32'h0);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_o_valid", {31'b0, o_valid}, 32'h0);
    checkOutput("t6_o_pc_plus_4", o_pc_plus_4, 32'h0);
    checkOutput("t6_o_Instruction", o_Instruction, 32'h0);
    checkOutput("t6_imem_req", {31'b0, imem_req}, 32'h0);
    checkOutput("t6_imem_addr", imem_addr, RESET_ADDR);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    resetModel();
    latKnob = 1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_restart_req", {31'b0, imem_req}, 32'h1);
    checkOutput("t6_restart_addr", imem_addr, RESET_ADDR);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_restart_instr", o_Instruction, 32'h2408_0001);

    // Random traffic: stalls, redirects, variable ready and latency
    latKnob = 0;
    for (int i = 0; i < 1500; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] tgt;
      readyKnob = ($urandom_range(0, 9) < 7);
      st        = ($urandom_range(0, 9) < 3);
      rd        = ($urandom_range(0, 99) < 8);
      tgt       = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      applyStimulus(st, rd, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
